// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event scheduler: FSM encoding and channel-index width.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_det_cell.sv
// One channel's front end: synchroniser, sample/prev flops and a gated 1->0 detector.
module edge_det_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic fall
);

  // chain[SYNC_STAGES] is the sample flop behind the synchroniser stages
  logic [SYNC_STAGES:0] chain;
  logic                 s, p;

  assign s = chain[SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      p     <= 1'b0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i <= SYNC_STAGES; i++) chain[i] <= chain[i-1];
      p <= s;
    end
  end

  assign fall = p & ~s & en;

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel falling-edge scheduler: latches edges as pending events and
// serialises them round-robin onto a single valid/ready event port.
module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] ovf_clr
);

  logic [NUM_CH-1:0] fall, acc, pend_d, ovf_d;
  state_e            state, state_d;
  logic [CH_W-1:0]   ptr, ptr_d, ch_d, win;
  logic              found;
  int                idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .din  (ch_in[i]),
      .en   (ch_en[i]),
      .fall (fall[i])
    );
  end

  // evt_valid is the OFFER state itself, so an async reset drops it at once
  assign evt_valid = (state == OFFER);

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_CH; i++)
      acc[i] = evt_valid & evt_ready & (evt_ch == CH_W'(i));
    // a fresh edge on the channel being accepted re-arms it without overflow
    pend_d = ch_en & (fall | (pend & ~acc));
    ovf_d  = (fall & pend & ~acc) | (ovf & ~ovf_clr);
  end

  // rotating priority search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    ch_d    = evt_ch;
    ptr_d   = ptr;
    case (state)
      IDLE: if (found) begin
        state_d = OFFER;
        ch_d    = win;
      end
      OFFER: if (evt_ready) begin
        state_d = IDLE;
        ptr_d   = (evt_ch == CH_W'(NUM_CH - 1)) ? '0 : evt_ch + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      evt_ch <= '0;
      ptr    <= '0;
      pend   <= '0;
      ovf    <= '0;
    end else begin
      state  <= state_d;
      evt_ch <= ch_d;
      ptr    <= ptr_d;
      pend   <= pend_d;
      ovf    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler (NUM_CH=4, SYNC_STAGES=2).
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_in, ch_en, ovf_clr, pend, ovf;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_ch;
  int         n_chk = 0;
  int         n_fail = 0;

  edge_event_scheduler #(.NUM_CH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_in     (ch_in),
    .ch_en     (ch_en),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .pend      (pend),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // all driving and sampling happens 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq2 [3];
    logic [1:0] seq2b[2];
    seq2  = '{2'd0, 2'd1, 2'd3};
    seq2b = '{2'd0, 2'd1};

    rst = 1'b0; ch_in = 4'hF; ch_en = 4'hF; evt_ready = 1'b1; ovf_clr = 4'h0;
    tick(2);
    chk("rst valid", 32'(evt_valid), 0);
    chk("rst ch",    32'(evt_ch),    0);
    chk("rst pend",  32'(pend),      0);
    chk("rst ovf",   32'(ovf),       0);
    rst = 1'b1;
    tick(6);
    chk("high at release no evt", 32'(evt_valid), 0);
    chk("high at release pend",   32'(pend),      0);

    // T1: single fall on ch 2, latency
    ch_in[2] = 1'b0;
    tick(3); chk("t1 pend k+2",  32'(pend), 0);
    tick(1); chk("t1 pend k+3",  32'(pend), 4'h4);
             chk("t1 valid k+3", 32'(evt_valid), 0);
    tick(1); chk("t1 valid k+4", 32'(evt_valid), 1);
             chk("t1 ch k+4",    32'(evt_ch), 2);
    tick(1); chk("t1 valid k+5", 32'(evt_valid), 0);
             chk("t1 pend k+5",  32'(pend), 0);
    ch_in[2] = 1'b1;
    tick(6); chk("t1 rise no evt", 32'(evt_valid), 0);

    // T2: simultaneous falls, round-robin order
    rst = 1'b0; tick(1); rst = 1'b1; tick(6);
    ch_in = 4'b0100;
    tick(4); chk("t2 pend", 32'(pend), 4'b1011);
    for (int j = 0; j < 3; j++) begin
      tick(1); chk("t2 valid", 32'(evt_valid), 1);
               chk("t2 ch",    32'(evt_ch), 32'(seq2[j]));
      tick(1); chk("t2 gap",   32'(evt_valid), 0);
    end
    chk("t2 pend done", 32'(pend), 0);
    ch_in = 4'hF; tick(6);
    ch_in = 4'b1100;
    tick(4); chk("t2b pend", 32'(pend), 4'b0011);
    for (int j = 0; j < 2; j++) begin
      tick(1); chk("t2b valid", 32'(evt_valid), 1);
               chk("t2b ch",    32'(evt_ch), 32'(seq2b[j]));
      tick(1); chk("t2b gap",   32'(evt_valid), 0);
    end
    ch_in = 4'hF; tick(6);

    // T3: stalled offer holds, second fall overflows, ovf_clr
    evt_ready = 1'b0;
    ch_in[1] = 1'b0;
    tick(5); chk("t3 offer valid", 32'(evt_valid), 1);
             chk("t3 offer ch",    32'(evt_ch), 1);
    ch_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t3 hold valid", 32'(evt_valid), 1);
      chk("t3 hold ch",    32'(evt_ch), 1);
      if (i == 3) ch_in[1] = 1'b0;
      if (i == 4) ch_in[1] = 1'b1;
    end
    chk("t3 ovf set",  32'(ovf),  4'b0010);
    chk("t3 pend set", 32'(pend), 4'b0010);
    evt_ready = 1'b1;
    tick(1); chk("t3 accept valid", 32'(evt_valid), 0);
             chk("t3 accept pend",  32'(pend), 0);
             chk("t3 ovf sticky",   32'(ovf), 4'b0010);
    ovf_clr = 4'b0010;
    tick(1); ovf_clr = 4'h0;
    chk("t3 ovf clr", 32'(ovf), 0);
    tick(5);

    // T4: fall in the same cycle the offer is accepted
    evt_ready = 1'b0;
    ch_in[2] = 1'b0; tick(1); ch_in[2] = 1'b1;
    tick(4); chk("t4 offer valid", 32'(evt_valid), 1);
             chk("t4 offer ch",    32'(evt_ch), 2);
    ch_in[2] = 1'b0; tick(1); ch_in[2] = 1'b1;
    tick(2); evt_ready = 1'b1;
    tick(1); chk("t4 pend kept", 32'(pend), 4'b0100);
             chk("t4 no ovf",    32'(ovf), 0);
             chk("t4 gap",       32'(evt_valid), 0);
    tick(1); chk("t4 2nd valid", 32'(evt_valid), 1);
             chk("t4 2nd ch",    32'(evt_ch), 2);
    tick(1); chk("t4 done valid", 32'(evt_valid), 0);
             chk("t4 done pend",  32'(pend), 0);
    tick(5);

    // T5: disabled channel ignored; dropping enable clears a pending event
    ch_en = 4'b0111;
    ch_in[3] = 1'b0;
    tick(5); chk("t5 dis pend",  32'(pend), 0);
             chk("t5 dis valid", 32'(evt_valid), 0);
    ch_in[3] = 1'b1;
    tick(5); chk("t5 dis pend2",  32'(pend), 0);
             chk("t5 dis valid2", 32'(evt_valid), 0);
    ch_en = 4'hF;
    evt_ready = 1'b0;
    ch_in[1] = 1'b0;
    tick(5); chk("t5 busy valid", 32'(evt_valid), 1);
             chk("t5 busy ch",    32'(evt_ch), 1);
    ch_in[0] = 1'b0; ch_in[1] = 1'b1;
    tick(4); chk("t5 pend0 set", 32'(pend), 4'b0011);
    ch_en[0] = 1'b0;
    tick(1); chk("t5 pend0 clr", 32'(pend), 4'b0010);
    ch_en = 4'hF; evt_ready = 1'b1;
    tick(1); chk("t5 acc valid", 32'(evt_valid), 0);
             chk("t5 acc pend",  32'(pend), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1); chk("t5 no ch0 evt", 32'(evt_valid), 0);
    end
    ch_in[0] = 1'b1; tick(6);

    // T6: async reset mid-offer, then a high line makes no event
    evt_ready = 1'b0;
    ch_in = 4'b1001;
    tick(5); chk("t6 offer valid", 32'(evt_valid), 1);
             chk("t6 offer ch",    32'(evt_ch), 2);
             chk("t6 pend",        32'(pend), 4'b0110);
    ch_in = 4'b1101;
    tick(4); ch_in[2] = 1'b0;
    tick(4); chk("t6 ovf", 32'(ovf), 4'b0100);
    ch_in = 4'hF;
    rst = 1'b0;
    #1;
    chk("t6 async valid", 32'(evt_valid), 0);
    chk("t6 async pend",  32'(pend), 0);
    chk("t6 async ovf",   32'(ovf), 0);
    chk("t6 async ch",    32'(evt_ch), 0);
    tick(2); rst = 1'b1; evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1); chk("t6 no evt", 32'(evt_valid), 0);
    end
    chk("t6 pend idle", 32'(pend), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
